// File: rtl/refill_arbiter.sv
// Main-memory bus arbiter for the I-cache refill port and the D-cache
// refill/writeback port. A grant covers one full line burst of BEATS words;
// the arbiter generates the beat addresses and routes data between the owner
// and memory. Simultaneous requests are settled round-robin.
//
// Handshake rule (memory side): a beat transfers in any cycle where
// m_valid & m_ready. While m_ready is low the beat is held with identical
// address and data; m_valid only drops outside BURST (or on reset).
module refill_arbiter #(
  parameter int BEATS      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_wready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  m_valid,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BW = $clog2(BEATS);
  // Clears the byte offset within a line so bursts always start aligned.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BEATS * 4 - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t                state;
  logic                  own_i;    // one-hot owner; both 0 when the bus is free
  logic                  own_d;
  logic                  last_d;   // last completed owner was D
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] base;
  logic [BW-1:0]         beat;
  logic                  hs;
  logic                  pick_d;

  // D wins when it is the only requester, or on a tie when I went last.
  always_comb begin
    pick_d = d_req & (~i_req | ~last_d);
  end

  // Arbitration FSM: grant, walk the burst beats, then release the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      own_i  <= 1'b0;
      own_d  <= 1'b0;
      last_d <= 1'b0;
      we_q   <= 1'b0;
      base   <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            own_d <= pick_d;
            own_i <= ~pick_d;
            we_q  <= pick_d & d_we;
            base  <= (pick_d ? d_addr : i_addr) & LINE_MASK;
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (hs) begin
            // Beat counter wraps naturally after the last beat.
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= DONE;
          end
        end
        DONE: begin
          last_d <= own_d;
          own_i  <= 1'b0;
          own_d  <= 1'b0;
          we_q   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side beat request; the offset is OR-free addition into an aligned
  // base, so it can never carry out of the line.
  always_comb begin
    m_valid = (state == BURST);
    hs      = m_valid & m_ready;
    m_we    = m_valid & we_q;
    m_addr  = m_valid ? (base + ADDR_WIDTH'({beat, 2'b00})) : '0;
    m_wdata = own_d ? d_wdata : '0;
  end

  // Requester-side grants, beat strobes and completion pulses.
  always_comb begin
    i_gnt     = own_i;
    d_gnt     = own_d;
    i_rvalid  = hs & ~we_q & own_i;
    d_rvalid  = hs & ~we_q & own_d;
    d_wready  = hs & we_q & own_d;
    i_rdata   = m_rdata;
    d_rdata   = m_rdata;
    i_done    = (state == DONE) & own_i;
    d_done    = (state == DONE) & own_d;
    busy      = (state != IDLE);
    state_dbg = state;
  end

endmodule
